// File: rtl/sipo_frame_deserializer.sv
// LSB-first serial-to-parallel receive stage with framing restart detection and a
// one-entry valid/ready output buffer that flags sticky overruns.
module sipo_frame_deserializer #(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             serial_in,
   input  logic             serial_valid,
   input  logic             frame_start,
   input  logic             out_ready,
   input  logic             overrun_clr,
   output logic [WIDTH-1:0] parallel_out,
   output logic             out_valid,
   output logic             busy,
   output logic [CNT_W-1:0] bit_count,
   output logic             frame_err,
   output logic             overrun
);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t           state;
   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] shift_nxt;
   logic             last_bit;
   logic             can_load;

   if (WIDTH < 2) begin : g_width_chk
      $error("sipo_frame_deserializer: WIDTH must be at least 2");
   end

   assign shift_nxt = {serial_in, shift_reg[WIDTH-1:1]};
   assign last_bit  = (bit_count == CNT_W'(WIDTH - 1));
   // Buffer can take a new word if empty or being drained on this same edge.
   assign can_load  = !out_valid || out_ready;
   assign busy      = (state == SHIFT);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= IDLE;
         shift_reg    <= '0;
         parallel_out <= '0;
         out_valid    <= 1'b0;
         bit_count    <= '0;
         frame_err    <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         if (overrun_clr)
            overrun <= 1'b0;
         if (out_valid && out_ready)
            out_valid <= 1'b0;

         if (serial_valid) begin
            case (state)
               IDLE: begin
                  if (frame_start) begin
                     shift_reg <= shift_nxt;
                     bit_count <= CNT_W'(1);
                     state     <= SHIFT;
                  end
               end
               SHIFT: begin
                  shift_reg <= shift_nxt;
                  if (frame_start) begin
                     bit_count <= CNT_W'(1);
                     frame_err <= 1'b1;
                  end else if (last_bit) begin
                     bit_count <= '0;
                     state     <= IDLE;
                     // Later assignments override the drain/clear defaults above.
                     if (can_load) begin
                        parallel_out <= shift_nxt;
                        out_valid    <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                  end else begin
                     bit_count <= bit_count + CNT_W'(1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sipo_frame_deserializer.sv
// Randomized plus directed bench for sipo_frame_deserializer; a bit-queue reference
// model predicts every output and a scoreboard checks each word the consumer takes.
module tb_sipo_frame_deserializer;

   localparam int W  = 4;
   localparam int CW = $clog2(W + 1);

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          serial_in = 1'b0;
   logic          serial_valid = 1'b0;
   logic          frame_start = 1'b0;
   logic          out_ready = 1'b0;
   logic          overrun_clr = 1'b0;
   logic [W-1:0]  parallel_out;
   logic          out_valid;
   logic          busy;
   logic [CW-1:0] bit_count;
   logic          frame_err;
   logic          overrun;

   sipo_frame_deserializer #(.WIDTH(W)) dut (
      .clk(clk), .reset_n(reset_n), .serial_in(serial_in), .serial_valid(serial_valid),
      .frame_start(frame_start), .out_ready(out_ready), .overrun_clr(overrun_clr),
      .parallel_out(parallel_out), .out_valid(out_valid), .busy(busy),
      .bit_count(bit_count), .frame_err(frame_err), .overrun(overrun)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: the partial word is just a list of received bits.
   bit cur[$];
   bit in_frame = 0;
   int exp_word = 0;
   bit exp_valid = 0;
   bit exp_ferr = 0;
   bit exp_ovr = 0;
   int sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_outputs();
      chk("parallel_out", 32'(parallel_out), 32'(exp_word));
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      chk("busy", 32'(busy), 32'(in_frame));
      chk("bit_count", 32'(bit_count), 32'(cur.size()));
      chk("frame_err", 32'(frame_err), 32'(exp_ferr));
      chk("overrun", 32'(overrun), 32'(exp_ovr));
   endtask

   // Predicts the state after the coming rising edge from the inputs just driven.
   task automatic model_edge(input bit rst_n, input bit sv, input bit sin, input bit fs,
                             input bit rdy, input bit clr);
      bit was_valid;
      int w;
      if (!rst_n) begin
         cur.delete(); in_frame = 0; exp_word = 0; exp_valid = 0;
         exp_ferr = 0; exp_ovr = 0; sb.delete();
         return;
      end
      was_valid = exp_valid;
      exp_ferr = 0;
      if (clr) exp_ovr = 0;
      if (was_valid && rdy) exp_valid = 0;
      if (sv) begin
         if (fs) begin
            if (in_frame) exp_ferr = 1;
            cur.delete(); cur.push_back(sin); in_frame = 1;
         end else if (in_frame) begin
            cur.push_back(sin);
            if (cur.size() == W) begin
               w = 0;
               foreach (cur[i]) w += int'(cur[i]) << i;
               cur.delete(); in_frame = 0;
               if (!was_valid || rdy) begin
                  exp_valid = 1; exp_word = w; sb.push_back(w);
               end else begin
                  exp_ovr = 1;
               end
            end
         end
      end
   endtask

   task automatic step(input bit rst_n, input bit sv, input bit sin, input bit fs,
                       input bit rdy, input bit clr);
      @(negedge clk);
      check_outputs();
      reset_n = rst_n; serial_valid = sv; serial_in = sin; frame_start = fs;
      out_ready = rdy; overrun_clr = clr;
      model_edge(rst_n, sv, sin, fs, rdy, clr);
   endtask

   task automatic send(input logic [W-1:0] word, input int gap, input bit rdy,
                       input bit rdy_last);
      for (int i = 0; i < W; i++) begin
         step(1, 1, word[i], i == 0, (i == W - 1) ? rdy_last : rdy, 0);
         if (i != W - 1)
            for (int g = 0; g < gap; g++) step(1, 0, 0, 0, rdy, 0);
      end
   endtask

   // Scoreboard monitor: every consumer transfer must deliver the oldest loaded word.
   always @(negedge clk) begin
      #2;
      if (reset_n && out_valid === 1'b1 && out_ready) begin
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_transfer: got %0h expected none (scoreboard empty)", parallel_out);
         end else begin
            chk("sb_transfer", 32'(parallel_out), 32'(sb.pop_front()));
         end
      end
   end

   initial begin
      bit r, sv, fs, rdy, clr;
      repeat (2) @(negedge clk);

      // Basic word, then one-cycle consume
      send(4'hB, 0, 0, 0);
      step(1, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0);
      // Gapped input
      send(4'h6, 3, 0, 0);
      step(1, 0, 0, 0, 1, 0);
      // Restart inside a partial word
      step(1, 1, 1, 1, 0, 0);
      step(1, 1, 0, 0, 0, 0);
      send(4'hC, 0, 0, 0);
      step(1, 0, 0, 0, 1, 0);
      // Overrun, clear, then drain
      send(4'hA, 0, 0, 0);
      send(4'h5, 0, 0, 0);
      step(1, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0);
      // Completion on the transfer edge
      send(4'h3, 0, 0, 0);
      send(4'h9, 0, 0, 1);
      step(1, 0, 0, 0, 0, 0);
      // Overrun set and clear on the same edge: set wins
      send(4'h2, 0, 0, 0);
      step(1, 1, 1, 1, 0, 0); step(1, 1, 1, 0, 0, 0); step(1, 1, 1, 0, 0, 0);
      step(1, 1, 1, 0, 0, 1);
      step(1, 0, 0, 0, 1, 1);
      // Reset mid-word, ignored bits, then a clean frame
      step(1, 1, 1, 1, 0, 0);
      step(1, 1, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0);
      send(4'h7, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         r   = ($urandom_range(199) != 0);
         sv  = ($urandom_range(9) < 6);
         fs  = in_frame ? ($urandom_range(19) == 0) : ($urandom_range(1) == 0);
         rdy = ($urandom_range(1) == 0);
         clr = ($urandom_range(9) == 0);
         step(r, sv, 1'($urandom_range(1)), fs, r ? rdy : 1'b0, clr);
      end
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
